sha256_block_ctrl: RTL and testbench
====================================

SHA256_BLOCK_CTRL -- requirements
Module: sha256_block_ctrl

Interface
REQ-001 SHALL have one clock; reset is synchronous and active-high.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request to hash one 512-bit block; accepted only when ready=1.
REQ-005 first  input  1  sampled with accepted start; 1 = chain value is loaded from the standard IV, 0 = chain from the current digest.
REQ-006 block  input  512  message block, sampled with accepted start; W0 = block[511:480], W15 = block[31:0].
REQ-007 ready  output  1  high only in IDLE.
REQ-008 busy  output  1  equals the inverse of ready.
REQ-009 digest_valid  output  1  one-cycle pulse when the digest is updated.
REQ-010 digest  output  256  chain value H0..H7; H0 = digest[255:224].
REQ-011 round  output  6  current round index; 0 outside ROUND.

Function
REQ-012 SHALL instantiate the team's sha256_S0, sha256_S1, sha256_s0, sha256_s1 and sha256_Krom blocks; sha256_Krom has registered output, so K is valid one cycle after its address.
REQ-013 States SHALL be IDLE, LOAD, ROUND and UPDATE; encoding is free.
REQ-014 IDLE: on start&ready, latch block into a 16-word W shift buffer.
REQ-015 IDLE: on start&ready, if first=1, load H0..H7 and a..h from the IV (6a09e667 bb67ae85 3c6ef372 a54ff53a 510e527f 9b05688c 1f83d9ab 5be0cd19); otherwise load a..h from H.
REQ-016 IDLE: on start&ready, drive the K ROM address to 0 and go to LOAD.
REQ-017 LOAD: one cycle for ROM latency; drive the ROM address to 1; go to ROUND with round=0.
REQ-018 ROUND, per cycle t: T1 = h+S1(e)+Ch(e,f,g)+K[t]+W[t]; T2 = S0(a)+Maj(a,b,c); all adds mod 2^32.
REQ-019 ROUND register update: h<=g, g<=f, f<=e, e<=d+T1, d<=c, c<=b, b<=a, a<=T1+T2.
REQ-020 W[t] SHALL be the buffer head for t<16 and s1(W[t-2])+W[t-7]+s0(W[t-15])+W[t-16] mod 2^32 for t>=16.
REQ-021 The W buffer shifts one word per ROUND cycle; the new tail is the next schedule word.
REQ-022 During ROUND the ROM address SHALL be round+1 mod 64; the wrap to 0 at round 63 is harmless.
REQ-023 round increments each ROUND cycle; at round=63 go to UPDATE.
REQ-024 UPDATE: Hi <= Hi + working variable i (mod 2^32); go to IDLE.
REQ-025 digest_valid SHALL be 1 in the first IDLE cycle after UPDATE, else 0.
REQ-026 Latency: start accepted in cycle N -> LOAD N+1 -> ROUND N+2..N+65 -> UPDATE N+66 -> digest_valid=1 and ready=1 in N+67.
REQ-027 start while busy SHALL be ignored, with no latching and no state change.
REQ-028 A start in the digest_valid cycle SHALL be accepted, giving back-to-back blocks with 67-cycle spacing.
REQ-029 digest SHALL be constant except at the end of UPDATE, at reset and at first=1 acceptance.
REQ-030 first and block are don't-care except in the acceptance cycle.

Reset
REQ-031 While rst=1 at a clock edge: state<=IDLE, H<=IV, round<=0, digest_valid<=0.
REQ-032 After that edge: ready=1, busy=0, digest=IV.
REQ-033 rst SHALL take priority over start in the same cycle.
REQ-034 rst mid-operation (LOAD/ROUND/UPDATE) SHALL abort the block with no digest_valid pulse and no H update.
REQ-035 W and a..h need no reset.

Verification
REQ-036 Bench SHALL cover "abc": first=1, block=61626380 00000000x14 00000018 -> digest_valid exactly 67 cycles after acceptance; digest=ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad.
REQ-037 Bench SHALL cover the empty message: first=1, block=80000000 then zeros -> digest=e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855.
REQ-038 Bench SHALL cover the 448-bit "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq" in two blocks: first=1 then first=0, with the second start in the digest_valid cycle -> final digest=248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1; second pulse 67 cycles after first.
REQ-039 Bench SHALL cover start pulsed during ROUND with different block/first -> ignored; "abc" digest unchanged and on time.
REQ-040 Bench SHALL cover rst at round 30 of a block -> no digest_valid; next cycle ready=1, digest=IV; then "abc" with first=0 -> correct "abc" digest.
REQ-041 Bench SHALL cover rst and start high in the same cycle -> start ignored, ready=1 the next cycle.

Source files
------------

// File: rtl/sha256_block_ctrl.sv
// SHA-256 single-block compression controller with its helper sigma functions and K ROM.
// One 512-bit block is hashed per start; the chain value is kept in digest between blocks.

module sha256_S0 (
   input  logic [31:0] x,
   output logic [31:0] y_c
);
   assign y_c = {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
endmodule

module sha256_S1 (
   input  logic [31:0] x,
   output logic [31:0] y_c
);
   assign y_c = {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
endmodule

module sha256_s0 (
   input  logic [31:0] x,
   output logic [31:0] y_c
);
   assign y_c = {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
endmodule

module sha256_s1 (
   input  logic [31:0] x,
   output logic [31:0] y_c
);
   assign y_c = {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
endmodule

// Round-constant ROM; k follows addr by one clock.
module sha256_Krom (
   input  logic        clk,
   input  logic [5:0]  addr,
   output logic [31:0] k
);
   localparam logic [31:0] K_TAB [64] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
      32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
      32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
      32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
      32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
      32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
      32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
      32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
      32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };

   always_ff @(posedge clk) begin
      k <= K_TAB[addr];
   end
endmodule

module sha256_block_ctrl (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic         first,
   input  logic [511:0] block,
   output logic         ready,
   output logic         busy,
   output logic         digest_valid,
   output logic [255:0] digest,
   output logic [5:0]   round
);
   localparam int unsigned WORD_W  = 32;
   localparam int unsigned ROUND_W = 6;

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_LOAD   = 2'd1;
   localparam logic [1:0] S_ROUND  = 2'd2;
   localparam logic [1:0] S_UPDATE = 2'd3;

   localparam logic [255:0] IV = {
      32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
      32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
   };

   logic [1:0]          state;
   logic [1:0]          state_nxt;
   logic                accept_c;
   logic [ROUND_W-1:0]  rom_addr_c;

   logic [WORD_W-1:0]   a, b, c, d, e, f, g, h;
   logic [WORD_W-1:0]   w [16];
   logic [WORD_W-1:0]   k_rom;
   logic [WORD_W-1:0]   k_first;

   logic [WORD_W-1:0]   big_s0_c, big_s1_c, sml_s0_c, sml_s1_c;
   logic [WORD_W-1:0]   ch_c, maj_c, k_t_c, t1_c, t2_c, w_new_c;
   logic [255:0]        work_c;
   logic [255:0]        digest_sum_c;

   assign accept_c = start && !rst && (state == S_IDLE);

   sha256_S0 u_big_s0 (.x(a),     .y_c(big_s0_c));
   sha256_S1 u_big_s1 (.x(e),     .y_c(big_s1_c));
   sha256_s0 u_sml_s0 (.x(w[1]),  .y_c(sml_s0_c));
   sha256_s1 u_sml_s1 (.x(w[14]), .y_c(sml_s1_c));

   sha256_Krom u_krom (
      .clk  (clk),
      .addr (rom_addr_c),
      .k    (k_rom)
   );

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state and ROM look-ahead address
   always_comb begin
      state_nxt  = state;
      rom_addr_c = '0;
      case (state)
         S_IDLE: begin
            if (start) state_nxt = S_LOAD;
         end
         S_LOAD: begin
            rom_addr_c = 6'd1;
            state_nxt  = S_ROUND;
         end
         S_ROUND: begin
            rom_addr_c = round + 6'd1;
            if (round == 6'd63) state_nxt = S_UPDATE;
         end
         S_UPDATE: begin
            state_nxt = S_IDLE;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   // ROM runs one address ahead after LOAD, so round 0 uses the word captured in LOAD
   assign k_t_c   = (round == 6'd0) ? k_first : k_rom;
   assign ch_c    = (e & f) ^ (~e & g);
   assign maj_c   = (a & b) ^ (a & c) ^ (b & c);
   assign t1_c    = h + big_s1_c + ch_c + k_t_c + w[0];
   assign t2_c    = big_s0_c + maj_c;
   assign w_new_c = sml_s1_c + w[9] + sml_s0_c + w[0];
   assign work_c  = {a, b, c, d, e, f, g, h};

   always_comb begin
      digest_sum_c = '0;
      for (int i = 0; i < 8; i++) begin
         digest_sum_c[i*32 +: 32] = digest[i*32 +: 32] + work_c[i*32 +: 32];
      end
   end

   // Status, round counter and chain value
   always_ff @(posedge clk) begin
      if (rst) begin
         ready        <= 1'b1;
         busy         <= 1'b0;
         digest_valid <= 1'b0;
         round        <= '0;
         digest       <= IV;
      end else begin
         ready        <= (state_nxt == S_IDLE);
         busy         <= (state_nxt != S_IDLE);
         digest_valid <= (state == S_UPDATE);
         round        <= (state == S_ROUND) ? round + 6'd1 : 6'd0;
         if (accept_c && first) begin
            digest <= IV;
         end else if (state == S_UPDATE) begin
            digest <= digest_sum_c;
         end
      end
   end

   // Message schedule buffer and working variables
   always_ff @(posedge clk) begin
      if (accept_c) begin
         for (int i = 0; i < 16; i++) begin
            w[i] <= block[(15-i)*32 +: 32];
         end
         {a, b, c, d, e, f, g, h} <= first ? IV : digest;
      end else if (state == S_ROUND) begin
         for (int i = 0; i < 15; i++) begin
            w[i] <= w[i+1];
         end
         w[15] <= w_new_c;
         h <= g;
         g <= f;
         f <= e;
         e <= d + t1_c;
         d <= c;
         c <= b;
         b <= a;
         a <= t1_c + t2_c;
      end
      if (state == S_LOAD) begin
         k_first <= k_rom;
      end
   end
endmodule

// File: tb/tb_sha256_block_ctrl.sv
// Directed bench for sha256_block_ctrl using FIPS 180-2 example messages.
// Inputs change 1 time unit after the rising edge; outputs are sampled at the same point.

module tb_sha256_block_ctrl;
   logic         clk;
   logic         rst;
   logic         start;
   logic         first;
   logic [511:0] block;
   logic         ready;
   logic         busy;
   logic         digest_valid;
   logic [255:0] digest;
   logic [5:0]   round;

   int checks = 0;
   int errors = 0;

   localparam logic [255:0] IV =
      256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
   localparam logic [255:0] ABC_D =
      256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
   localparam logic [255:0] EMPTY_D =
      256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
   localparam logic [255:0] TWO_D =
      256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

   localparam logic [511:0] ABC_B   = {32'h61626380, {14{32'h00000000}}, 32'h00000018};
   localparam logic [511:0] EMPTY_B = {32'h80000000, {15{32'h00000000}}};
   localparam logic [511:0] M1_B = {
      32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
      32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
      32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
      32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000
   };
   localparam logic [511:0] M2_B = {{15{32'h00000000}}, 32'h000001c0};

   sha256_block_ctrl dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .first        (first),
      .block        (block),
      .ready        (ready),
      .busy         (busy),
      .digest_valid (digest_valid),
      .digest       (digest),
      .round        (round)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present a block for one edge; afterwards scramble the don't-care inputs.
   task automatic start_block(input logic [511:0] blk, input logic f);
      block = blk;
      first = f;
      start = 1'b1;
      tick();
      start = 1'b0;
      first = ~f;
      block = ~blk;
   endtask

   // Count cycles since acceptance until digest_valid, bounded.
   task automatic wait_dv(input int from, output int lat);
      lat = from;
      while (digest_valid !== 1'b1 && lat < 100) begin
         tick();
         lat++;
      end
   endtask

   initial begin
      int lat;
      int seen;

      rst   = 1'b1;
      start = 1'b0;
      first = 1'b0;
      block = '0;
      repeat (3) tick();
      check("rst_ready",  256'(ready),        256'd1);
      check("rst_busy",   256'(busy),         256'd0);
      check("rst_dv",     256'(digest_valid), 256'd0);
      check("rst_round",  256'(round),        256'd0);
      check("rst_digest", digest,             IV);
      rst = 1'b0;
      tick();

      // "abc"
      start_block(ABC_B, 1'b1);
      check("abc_busy",  256'(busy),  256'd1);
      check("abc_ready", 256'(ready), 256'd0);
      check("abc_round_load", 256'(round), 256'd0);
      wait_dv(1, lat);
      check("abc_latency", 256'(lat), 256'd67);
      check("abc_digest", digest, ABC_D);
      check("abc_ready_at_dv", 256'(ready), 256'd1);
      tick();
      check("abc_dv_pulse", 256'(digest_valid), 256'd0);
      check("abc_digest_hold", digest, ABC_D);

      // empty message
      start_block(EMPTY_B, 1'b1);
      wait_dv(1, lat);
      check("empty_latency", 256'(lat), 256'd67);
      check("empty_digest", digest, EMPTY_D);

      // two-block message, second start in the digest_valid cycle
      start_block(M1_B, 1'b1);
      wait_dv(1, lat);
      check("two_lat1", 256'(lat), 256'd67);
      start_block(M2_B, 1'b0);
      check("two_busy2", 256'(busy), 256'd1);
      wait_dv(1, lat);
      check("two_lat2", 256'(lat), 256'd67);
      check("two_digest", digest, TWO_D);

      // start while busy is ignored
      start_block(ABC_B, 1'b1);
      repeat (20) tick();
      check("ign_round19", 256'(round), 256'd19);
      check("ign_digest_iv", digest, IV);
      block = EMPTY_B;
      first = 1'b0;
      start = 1'b1;
      tick();
      start = 1'b0;
      check("ign_round20", 256'(round), 256'd20);
      check("ign_busy", 256'(busy), 256'd1);
      wait_dv(22, lat);
      check("ign_latency", 256'(lat), 256'd67);
      check("ign_digest", digest, ABC_D);

      // reset at round 30 aborts the block
      start_block(ABC_B, 1'b0);
      repeat (31) tick();
      check("abort_round30", 256'(round), 256'd30);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("abort_ready",  256'(ready),        256'd1);
      check("abort_busy",   256'(busy),         256'd0);
      check("abort_dv",     256'(digest_valid), 256'd0);
      check("abort_round",  256'(round),        256'd0);
      check("abort_digest", digest,             IV);
      seen = 0;
      repeat (70) begin
         tick();
         if (digest_valid === 1'b1) seen++;
      end
      check("abort_no_dv", 256'(seen), 256'd0);
      start_block(ABC_B, 1'b0);
      wait_dv(1, lat);
      check("after_abort_latency", 256'(lat), 256'd67);
      check("after_abort_digest", digest, ABC_D);

      // reset wins over start
      tick();
      rst   = 1'b1;
      start = 1'b1;
      first = 1'b1;
      block = EMPTY_B;
      tick();
      rst   = 1'b0;
      start = 1'b0;
      check("rst_start_ready",  256'(ready),  256'd1);
      check("rst_start_busy",   256'(busy),   256'd0);
      check("rst_start_digest", digest,       IV);
      tick();
      check("rst_start_idle", 256'(ready), 256'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
